// File: rtl/round_key_store_if.sv
// Key-word write and round-key read bus between key expansion, the AES rounds and round_key_store.
// With RKS_PARITY_EN defined the read side also carries rd_perr.
interface round_key_store_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 4,
  parameter int CTX_WIDTH  = 1
);
  // Write handshake: a word transfers on a rising edge where wr_valid & wr_ready;
  // the master holds wr_ctx/wr_addr/wr_data stable while wr_valid is high and wr_ready low.
  // The read side has no backpressure: rd_req at one edge yields rd_valid for exactly one cycle.
  logic                  wr_valid;
  logic                  wr_ready;
  logic [CTX_WIDTH-1:0]  wr_ctx;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_err;
  logic                  rd_req;
  logic [CTX_WIDTH-1:0]  rd_ctx;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_miss;
`ifdef RKS_PARITY_EN
  logic                  rd_perr;

  modport master (
    output wr_valid, wr_ctx, wr_addr, wr_data, rd_req, rd_ctx, rd_addr,
    input  wr_ready, wr_err, rd_valid, rd_data, rd_miss, rd_perr
  );
  modport slave (
    input  wr_valid, wr_ctx, wr_addr, wr_data, rd_req, rd_ctx, rd_addr,
    output wr_ready, wr_err, rd_valid, rd_data, rd_miss, rd_perr
  );
`else
  modport master (
    output wr_valid, wr_ctx, wr_addr, wr_data, rd_req, rd_ctx, rd_addr,
    input  wr_ready, wr_err, rd_valid, rd_data, rd_miss
  );
  modport slave (
    input  wr_valid, wr_ctx, wr_addr, wr_data, rd_req, rd_ctx, rd_addr,
    output wr_ready, wr_err, rd_valid, rd_data, rd_miss
  );
`endif
endinterface

// File: rtl/round_key_store.sv
// Multi-context AES round-key buffer with per-word validity, per-context ready/lock and flush.
// Optional macro RKS_PARITY_EN adds per-byte even parity storage and the rd_perr check.
module round_key_store #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 11,
  parameter int NUM_CTX    = 2,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int CTX_WIDTH  = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  round_key_store_if.slave     kbus,
  input  logic                 lock_set,
  input  logic                 lock_clr,
  input  logic [CTX_WIDTH-1:0] lock_ctx,
  input  logic                 flush,
  input  logic [CTX_WIDTH-1:0] flush_ctx,
  output logic [NUM_CTX-1:0]   ctx_ready,
  output logic [NUM_CTX-1:0]   ctx_locked
);
  localparam int WORDS = NUM_CTX * DEPTH;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [CTX_WIDTH:0]  NCTX_L  = (CTX_WIDTH+1)'(NUM_CTX);

  function automatic logic ctx_ok(input logic [CTX_WIDTH-1:0] c);
    return {1'b0, c} < NCTX_L;
  endfunction

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [CTX_WIDTH-1:0] c,
                                                input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'(int'(c) * DEPTH + int'(a));
  endfunction

  // Storage is deliberately unreset; valid_q alone decides whether a word may be returned.
  logic [DATA_WIDTH-1:0] mem_q [WORDS];
  logic [WORDS-1:0]      valid_q, valid_d;
  logic [NUM_CTX-1:0]    ready_q, ready_d;
  logic [NUM_CTX-1:0]    locked_q, locked_d;
  logic                  rd_valid_q, rd_miss_q, wr_err_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic                  wr_in_range, wr_locked, wr_ready, wr_fire, wr_store;
  logic                  flush_ok, rd_in_range, rd_hit;
  logic [IDX_W-1:0]      wr_idx, rd_idx;

  always_comb begin
    wr_in_range = ctx_ok(kbus.wr_ctx) && addr_ok(kbus.wr_addr);
    rd_in_range = ctx_ok(kbus.rd_ctx) && addr_ok(kbus.rd_addr);
    wr_idx      = wr_in_range ? word_idx(kbus.wr_ctx, kbus.wr_addr) : '0;
    rd_idx      = rd_in_range ? word_idx(kbus.rd_ctx, kbus.rd_addr) : '0;
    rd_hit      = rd_in_range && valid_q[rd_idx];
    wr_locked   = 1'b0;
    flush_ok    = 1'b0;
    for (int c = 0; c < NUM_CTX; c++) begin
      if (kbus.wr_ctx == CTX_WIDTH'(c)) wr_locked = locked_q[c];
      if (flush && flush_ctx == CTX_WIDTH'(c)) flush_ok = !locked_q[c];
    end
    // A flush of the target context stalls the writer so the word is not lost to the flush.
    wr_ready = !wr_locked && !(flush && flush_ctx == kbus.wr_ctx);
    wr_fire  = kbus.wr_valid && wr_ready;
    wr_store = wr_fire && wr_in_range;
  end

  always_comb begin
    valid_d  = valid_q;
    locked_d = locked_q;
    for (int c = 0; c < NUM_CTX; c++) begin
      if (flush_ok && flush_ctx == CTX_WIDTH'(c)) valid_d[c*DEPTH +: DEPTH] = '0;
      if (lock_ctx == CTX_WIDTH'(c)) begin
        if (lock_clr)      locked_d[c] = 1'b0;
        else if (lock_set) locked_d[c] = 1'b1;
      end
    end
    if (wr_store) valid_d[wr_idx] = 1'b1;
    ready_d = '0;
    for (int c = 0; c < NUM_CTX; c++) ready_d[c] = &valid_d[c*DEPTH +: DEPTH];
  end

  always_ff @(posedge clk) begin
    if (wr_store) mem_q[wr_idx] <= kbus.wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      ready_q    <= '0;
      locked_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_miss_q  <= 1'b0;
      rd_data_q  <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      ready_q    <= ready_d;
      locked_q   <= locked_d;
      wr_err_q   <= wr_fire && !wr_in_range;
      rd_valid_q <= kbus.rd_req;
      rd_miss_q  <= kbus.rd_req && !rd_hit;
      // Read-first: mem_q/valid_q here are the pre-edge values even when written this cycle.
      if (kbus.rd_req) rd_data_q <= rd_hit ? mem_q[rd_idx] : '0;
    end
  end

`ifdef RKS_PARITY_EN
  localparam int PAR_W = DATA_WIDTH / 8;

  function automatic logic [PAR_W-1:0] byte_par(input logic [DATA_WIDTH-1:0] d);
    logic [PAR_W-1:0] p;
    for (int b = 0; b < PAR_W; b++) p[b] = ^d[8*b +: 8];
    return p;
  endfunction

  logic [PAR_W-1:0] par_q [WORDS];
  logic             rd_perr_q;

  always_ff @(posedge clk) begin
    if (wr_store) par_q[wr_idx] <= byte_par(kbus.wr_data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_perr_q <= 1'b0;
    else        rd_perr_q <= kbus.rd_req && rd_hit && (byte_par(mem_q[rd_idx]) != par_q[rd_idx]);
  end

  assign kbus.rd_perr = rd_perr_q;
`endif

  assign kbus.wr_ready = wr_ready;
  assign kbus.wr_err   = wr_err_q;
  assign kbus.rd_valid = rd_valid_q;
  assign kbus.rd_data  = rd_data_q;
  assign kbus.rd_miss  = rd_miss_q;
  assign ctx_ready     = ready_q;
  assign ctx_locked    = locked_q;
endmodule

// File: tb/tb_round_key_store.sv
// Directed bench for round_key_store: fill, read, lock, flush, read-first, range errors, reset mid-fill.
// With RKS_PARITY_EN defined it also exercises the parity check through a backdoor bit flip.
module tb_round_key_store;
  localparam int DW    = 128;
  localparam int DEPTH = 11;
  localparam int NCTX  = 2;
  localparam int AW    = 4;
  localparam int CW    = 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            lock_set, lock_clr, flush;
  logic [CW-1:0]   lock_ctx, flush_ctx;
  logic [NCTX-1:0] ctx_ready, ctx_locked;

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];

  round_key_store_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CTX_WIDTH(CW)) kbus ();

  round_key_store #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_CTX(NCTX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .kbus      (kbus),
    .lock_set  (lock_set),
    .lock_clr  (lock_clr),
    .lock_ctx  (lock_ctx),
    .flush     (flush),
    .flush_ctx (flush_ctx),
    .ctx_ready (ctx_ready),
    .ctx_locked(ctx_locked)
  );

  // clock/reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drivers
  task automatic wr_word(input logic [CW-1:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    kbus.wr_valid = 1'b1;
    kbus.wr_ctx   = c;
    kbus.wr_addr  = a;
    kbus.wr_data  = d;
    #1;
    check("wr_ready_free", kbus.wr_ready, 1);
    tick();
    kbus.wr_valid = 1'b0;
  endtask

  task automatic rd_word(input string tag, input logic [CW-1:0] c, input logic [AW-1:0] a,
                         input logic [DW-1:0] exp_d, input logic exp_miss);
    kbus.rd_req  = 1'b1;
    kbus.rd_ctx  = c;
    kbus.rd_addr = a;
    exp_q.push_back(exp_d);
    tick();
    kbus.rd_req = 1'b0;
    check({tag, "_valid"}, kbus.rd_valid, 1);
    check({tag, "_miss"}, kbus.rd_miss, exp_miss);
    check({tag, "_data"}, kbus.rd_data, exp_q.pop_front());
  endtask

  initial begin
    rst_n = 1'b0;
    lock_set = 1'b0; lock_clr = 1'b0; lock_ctx = '0;
    flush = 1'b0; flush_ctx = '0;
    kbus.wr_valid = 1'b0; kbus.wr_ctx = '0; kbus.wr_addr = '0; kbus.wr_data = '0;
    kbus.rd_req = 1'b0; kbus.rd_ctx = '0; kbus.rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctx_ready", ctx_ready, 0);
    check("rst_ctx_locked", ctx_locked, 0);
    check("rst_rd_valid", kbus.rd_valid, 0);
    check("rst_rd_miss", kbus.rd_miss, 0);
    check("rst_rd_data", kbus.rd_data, 0);
    check("rst_wr_err", kbus.wr_err, 0);
    rst_n = 1'b1;
    tick();

    // Fill ctx0; ready rises only once addr10 lands.
    for (int i = 0; i < DEPTH; i++) begin
      wr_word(1'b0, AW'(i), DW'(32'h1000 + i));
      if (i == DEPTH - 2) check("ready_partial", ctx_ready, 2'b00);
    end
    check("ready_ctx0_full", ctx_ready, 2'b01);
    rd_word("rd_ctx1_empty", 1'b1, 4'd3, 0, 1'b1);
    rd_word("rd_ctx0_a5", 1'b0, 4'd5, 128'h1005, 1'b0);
    tick();
    check("idle_rd_valid", kbus.rd_valid, 0);
    check("idle_rd_data_hold", kbus.rd_data, 128'h1005);

    // Lock ctx0: writes to it stall, ctx1 still writable.
    lock_set = 1'b1; lock_ctx = 1'b0;
    tick();
    lock_set = 1'b0;
    check("locked_ctx0", ctx_locked, 2'b01);
    kbus.wr_valid = 1'b1; kbus.wr_ctx = 1'b0; kbus.wr_addr = 4'd2; kbus.wr_data = 128'hDEAD;
    #1;
    check("wr_ready_locked", kbus.wr_ready, 0);
    tick();
    check("wr_ready_locked2", kbus.wr_ready, 0);
    kbus.wr_valid = 1'b0;
    wr_word(1'b1, 4'd2, 128'h2202);
    rd_word("rd_locked_a2", 1'b0, 4'd2, 128'h1002, 1'b0);
    rd_word("rd_ctx1_a2", 1'b1, 4'd2, 128'h2202, 1'b0);
    kbus.wr_valid = 1'b1; kbus.wr_ctx = 1'b0; kbus.wr_addr = 4'd2; kbus.wr_data = 128'hDEAD;
    lock_clr = 1'b1;
    #1;
    check("wr_ready_unlock_cycle", kbus.wr_ready, 0);
    tick();
    lock_clr = 1'b0;
    check("unlocked_ctx0", ctx_locked, 2'b00);
    check("wr_ready_after_clr", kbus.wr_ready, 1);
    tick();
    kbus.wr_valid = 1'b0;
    rd_word("rd_stalled_done", 1'b0, 4'd2, 128'hDEAD, 1'b0);
    check("ready_after_rewrite", ctx_ready, 2'b01);

    // Set and clear together: clear wins.
    lock_set = 1'b1; lock_ctx = 1'b1;
    tick();
    check("locked_ctx1", ctx_locked, 2'b10);
    lock_clr = 1'b1;
    tick();
    lock_set = 1'b0; lock_clr = 1'b0;
    check("set_clr_clr_wins", ctx_locked, 2'b00);

    // Flush of a locked context is ignored.
    lock_set = 1'b1; lock_ctx = 1'b0;
    tick();
    lock_set = 1'b0;
    flush = 1'b1; flush_ctx = 1'b0;
    tick();
    flush = 1'b0;
    check("flush_locked_ignored", ctx_ready, 2'b01);
    rd_word("rd_after_locked_flush", 1'b0, 4'd0, 128'h1000, 1'b0);
    lock_clr = 1'b1;
    tick();
    lock_clr = 1'b0;

    // Flush ctx0 with a concurrent write to ctx1; writer to the flushed context stalls.
    flush = 1'b1; flush_ctx = 1'b0;
    kbus.wr_valid = 1'b1; kbus.wr_ctx = 1'b0; kbus.wr_addr = 4'd1; kbus.wr_data = 128'hBAD;
    #1;
    check("wr_ready_flush_same", kbus.wr_ready, 0);
    kbus.wr_ctx = 1'b1; kbus.wr_addr = 4'd4; kbus.wr_data = 128'h55;
    #1;
    check("wr_ready_flush_other", kbus.wr_ready, 1);
    tick();
    flush = 1'b0; kbus.wr_valid = 1'b0;
    check("ready_after_flush", ctx_ready, 2'b00);
    rd_word("rd_flushed_a0", 1'b0, 4'd0, 0, 1'b1);
    rd_word("rd_ctx1_a4", 1'b1, 4'd4, 128'h55, 1'b0);

    // Read-first on a same-cycle write, for a valid and an invalid word.
    kbus.wr_valid = 1'b1; kbus.wr_ctx = 1'b1; kbus.wr_addr = 4'd4; kbus.wr_data = 128'hAA;
    rd_word("rd_first_old", 1'b1, 4'd4, 128'h55, 1'b0);
    kbus.wr_valid = 1'b0;
    rd_word("rd_after_write", 1'b1, 4'd4, 128'hAA, 1'b0);
    kbus.wr_valid = 1'b1; kbus.wr_ctx = 1'b1; kbus.wr_addr = 4'd5; kbus.wr_data = 128'h77;
    rd_word("rd_first_invalid", 1'b1, 4'd5, 0, 1'b1);
    kbus.wr_valid = 1'b0;

    // Out-of-range address: accepted, flagged, dropped.
    kbus.wr_valid = 1'b1; kbus.wr_ctx = 1'b0; kbus.wr_addr = 4'd11; kbus.wr_data = 128'hFFFF;
    #1;
    check("wr_ready_oor", kbus.wr_ready, 1);
    tick();
    kbus.wr_valid = 1'b0;
    check("wr_err_pulse", kbus.wr_err, 1);
    check("ready_after_oor", ctx_ready, 2'b00);
    tick();
    check("wr_err_clear", kbus.wr_err, 0);
    rd_word("rd_oor", 1'b0, 4'd11, 0, 1'b1);
    rd_word("rd_oor_a0_untouched", 1'b0, 4'd0, 0, 1'b1);

    // Fill ctx1 fully.
    for (int i = 0; i < DEPTH; i++) wr_word(1'b1, AW'(i), DW'(32'h2000 + i));
    check("ready_ctx1_full", ctx_ready, 2'b10);
    rd_word("rd_ctx1_a10", 1'b1, 4'd10, 128'h200A, 1'b0);

    // Reset in the middle of refilling ctx0.
    lock_set = 1'b1; lock_ctx = 1'b1;
    tick();
    lock_set = 1'b0;
    for (int i = 0; i < 5; i++) wr_word(1'b0, AW'(i), DW'(32'h3000 + i));
    rst_n = 1'b0;
    #1;
    check("midfill_rst_ready", ctx_ready, 2'b00);
    check("midfill_rst_locked", ctx_locked, 2'b00);
    tick();
    rst_n = 1'b1;
    tick();
    rd_word("rd_after_rst_ctx0", 1'b0, 4'd0, 0, 1'b1);
    rd_word("rd_after_rst_ctx1", 1'b1, 4'd0, 0, 1'b1);

`ifdef RKS_PARITY_EN
    wr_word(1'b0, 4'd6, 128'h66);
    wr_word(1'b0, 4'd7, 128'h77);
    dut.mem_q[7][0] = ~dut.mem_q[7][0];
    kbus.rd_req = 1'b1; kbus.rd_ctx = 1'b0; kbus.rd_addr = 4'd7;
    tick();
    kbus.rd_req = 1'b0;
    check("perr_flip_valid", kbus.rd_valid, 1);
    check("perr_flip", kbus.rd_perr, 1);
    check("perr_flip_data", kbus.rd_data, 128'h76);
    kbus.rd_req = 1'b1; kbus.rd_addr = 4'd6;
    tick();
    kbus.rd_req = 1'b0;
    check("perr_clean", kbus.rd_perr, 0);
    check("perr_clean_data", kbus.rd_data, 128'h66);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/round_key_store.md
Name: round_key_store

Overview:
- Parametrised, multi-context round-key buffer that replaces the single-context key RAM between key expansion and the AES round datapath.
- Holds NUM_CTX independent key schedules of DEPTH words each.
- Tracks per-word validity and per-context completeness, and protects a context in use by the cipher with a lock.
- Lets key expansion fill one context while the rounds read another (ping-pong keying).

Parameters:
- DATA_WIDTH, 128, width of one round key word.
- DEPTH, 11, round keys per context (Nr+1; 13/15 for AES-192/256).
- NUM_CTX, 2, number of independent key contexts.
- ADDR_WIDTH, $clog2(DEPTH), round index width.
- CTX_WIDTH, (NUM_CTX>1 ? $clog2(NUM_CTX) : 1), context select width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  key word write request.
- wr_ready  out  1  write accepted this cycle when wr_valid & wr_ready.
- wr_ctx  in  CTX_WIDTH  target context.
- wr_addr  in  ADDR_WIDTH  target round index.
- wr_data  in  DATA_WIDTH  round key word.
- wr_err  out  1  one-cycle pulse: accepted write had wr_addr>=DEPTH or wr_ctx>=NUM_CTX; word dropped.
- rd_req  in  1  read request (no backpressure).
- rd_ctx  in  CTX_WIDTH  read context.
- rd_addr  in  ADDR_WIDTH  read round index.
- rd_valid  out  1  read response strobe, one cycle after rd_req.
- rd_data  out  DATA_WIDTH  read data.
- rd_miss  out  1  with rd_valid: word not valid or out of range; rd_data=0.
- lock_set  in  1  lock context lock_ctx (cipher starts using it).
- lock_clr  in  1  unlock context lock_ctx.
- lock_ctx  in  CTX_WIDTH  context for lock_set/lock_clr.
- flush  in  1  invalidate all words of flush_ctx.
- flush_ctx  in  CTX_WIDTH  context to flush.
- ctx_ready  out  NUM_CTX  bit c = all DEPTH words of context c valid.
- ctx_locked  out  NUM_CTX  bit c = context c locked.

Behaviour:
- Reset (rst_n low, async): all valid bits, locks, ctx_ready, ctx_locked cleared; rd_valid, rd_miss, wr_err, rd_data = 0. Storage array is not reset; validity bits gate it.
- Storage: NUM_CTX*DEPTH words, one write and one read port per cycle, registered read.
- wr_ready is combinational: low when wr_ctx is locked, or flush is high with flush_ctx==wr_ctx; otherwise high.
- Accepted in-range write: stores the word, sets its valid bit next edge. Rewriting a valid word overwrites it; the bit stays set.
- Read: rd_req at edge N gives rd_valid at N+1 with rd_data/rd_miss. Read and write of the same word in one cycle return the old data (read-first) and rd_miss reflects the old valid bit.
- rd_valid without rd_req next cycle is 0; rd_data holds its last value.
- ctx_ready[c]: registered AND of the valid bits of context c; rises the cycle after the last missing word is written.
- Lock: lock_set sets ctx_locked[lock_ctx] next edge. lock_clr clears it. Both high at once: lock_clr wins. Out-of-range lock_ctx is ignored. Reads are allowed regardless of lock.
- Flush: clears all valid bits of flush_ctx next edge, plus ctx_ready[flush_ctx]. Flush of a locked context is ignored. Flush and an accepted write to another context in the same cycle both take effect.
- Reset mid-fill: all contexts revert to invalid; a partial schedule must be rewritten.

Optional Feature:
- RKS_PARITY_EN defined: each word stores DATA_WIDTH/8 even-parity bits, computed per byte on write. On read, the parity check runs in the same registered stage. Output rd_perr (1 bit) asserts with rd_valid on mismatch of a valid word. Port rd_perr and the parity storage exist only with the macro.
- RKS_PARITY_EN undefined: no parity storage, no rd_perr port; behaviour otherwise identical.

Test Plan:
- Reset, then write ctx0 addr0..10 with 128'h1000+i -> ctx_ready=2'b01 one cycle after the addr10 write. Reads of ctx0 addr5 -> rd_valid next cycle, rd_data=128'h1005, rd_miss=0.
- Read ctx1 addr3 after reset -> rd_valid=1, rd_miss=1, rd_data=0.
- lock_set ctx0, then wr_valid to ctx0 addr2 -> wr_ready=0, data unchanged (read returns 128'h1002). A concurrent write to ctx1 addr2 is accepted. After lock_clr, the stalled write completes.
- flush ctx0 while locked -> ctx_ready[0] stays 1. After unlock, flush ctx0 -> ctx_ready[0]=0 next cycle; read addr0 returns rd_miss=1.
- Same-cycle write ctx1 addr4 = 128'hAA and read ctx1 addr4 (old 128'h55) -> rd_data=128'h55; following read gives 128'hAA. Write to addr 11 -> wr_ready=1, wr_err pulse, no state change.
- RKS_PARITY_EN: force a bit flip in stored ctx0 addr7 via backdoor -> read gives rd_perr=1 with rd_valid. Clean words give rd_perr=0.
